// File: rtl/data_mem_responder.sv
// Memory-side responder for processor load/store requests.
// Accepts one request at a time, waits a fixed latency, then returns load data or a store acknowledge.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [31:0]     mem_q [DEPTH];

    logic            accept;
    logic            access;
    logic            addr_err;
    logic [AW-1:0]   idx;

    assign accept   = (state_q == IDLE) && req_valid;
    assign access   = (state_q == WAIT) && (cnt_q == '0);
    assign idx      = addr_q[AW+1:2];
    // Word-misaligned or any address bit beyond the backing store is an error.
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

    // Request is frozen at accept so later input changes cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (access) begin
            if (addr_err) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else if (wr_q) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_q[b]) begin
                        mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
                rdata_q <= '0;
                err_q   <= 1'b0;
            end else begin
                rdata_q <= mem_q[idx];
                err_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=2 instance for the main tests
// and a LATENCY=1 instance for back-to-back timing.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v0, rdy0, wr0, rv0, rr0, er0;
    logic [31:0] addr0, wd0, rd0;
    logic [3:0]  be0;
    logic        v1, rdy1, wr1, rv1, rr1, er1;
    logic [31:0] addr1, wd1, rd1;
    logic [3:0]  be1;

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(v0), .req_ready(rdy0), .req_write(wr0), .req_addr(addr0),
        .req_wdata(wd0), .req_be(be0),
        .rsp_valid(rv0), .rsp_ready(rr0), .rsp_rdata(rd0), .rsp_err(er0)
    );

    data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(v1), .req_ready(rdy1), .req_write(wr1), .req_addr(addr1),
        .req_wdata(wd1), .req_be(be1),
        .rsp_valid(rv1), .rsp_ready(rr1), .rsp_rdata(rd1), .rsp_err(er1)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   pv0 = 1'b0;
    bit   pv1 = 1'b0;
    int   last_acc1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic req0(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] erd, input logic eerr,
                        input bit push);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        v0 = 1'b1; wr0 = w; addr0 = a; wd0 = d; be0 = b;
        while (!rdy0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("d0_accept_ready", {31'b0, rdy0}, 32'd1);
        if (!rdy0) begin
            v0 = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (push) begin
            e.rd = erd; e.err = eerr; e.acc = cyc;
            q0.push_back(e);
        end
        // Scramble inputs so a design that re-samples them gets caught.
        v0 = 1'b0; wr0 = ~w; addr0 = ~a; wd0 = ~d; be0 = ~b;
    endtask

    task automatic req1(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] erd, input bit chk_sp);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        v1 = 1'b1; wr1 = w; addr1 = a; wd1 = d; be1 = b;
        while (!rdy1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("d1_accept_ready", {31'b0, rdy1}, 32'd1);
        if (!rdy1) begin
            v1 = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (chk_sp) chk("d1_accept_spacing", 32'(cyc - last_acc1), 32'd3);
        last_acc1 = cyc;
        e.rd = erd; e.err = 1'b0; e.acc = cyc;
        q1.push_back(e);
        v1 = 1'b0; wr1 = ~w; addr1 = ~a; wd1 = ~d; be1 = ~b;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || !rdy0 || !rdy1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_q0_empty", 32'(q0.size()), 32'd0);
        chk("drain_q1_empty", 32'(q1.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            pv0 = 1'b0;
        end else begin
            if (rv0 && !pv0) begin
                if (q0.size() == 0) chk("d0_unexpected_rsp", {31'b0, rv0}, 32'd0);
                else chk("d0_latency", 32'(cyc - q0[0].acc), 32'd2);
            end
            if (rv0 && rr0 && q0.size() != 0) begin
                e0 = q0.pop_front();
                chk("d0_rdata", rd0, e0.rd);
                chk("d0_err", {31'b0, er0}, {31'b0, e0.err});
            end
            pv0 = rv0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            pv1 = 1'b0;
        end else begin
            if (rv1 && !pv1) begin
                if (q1.size() == 0) chk("d1_unexpected_rsp", {31'b0, rv1}, 32'd0);
                else chk("d1_latency", 32'(cyc - q1[0].acc), 32'd1);
            end
            if (rv1 && rr1 && q1.size() != 0) begin
                e1 = q1.pop_front();
                chk("d1_rdata", rd1, e1.rd);
                chk("d1_err", {31'b0, er1}, {31'b0, e1.err});
            end
            pv1 = rv1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap_rd;
        logic        snap_err;
        int          n;

        rst = 1'b1;
        v0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0; be0 = '0; rr0 = 1'b1;
        v1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0; be1 = '0; rr1 = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_d0_req_ready", {31'b0, rdy0}, 32'd1);
        chk("rst_d0_rsp_valid", {31'b0, rv0}, 32'd0);
        chk("rst_d0_rdata", rd0, 32'd0);
        chk("rst_d0_err", {31'b0, er0}, 32'd0);
        chk("rst_d1_req_ready", {31'b0, rdy1}, 32'd1);
        chk("rst_d1_rsp_valid", {31'b0, rv1}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Basic store then load
        req0(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 1'b1);
        req0(1'b0, 32'h10, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0, 1'b1);
        // Byte-enable merge
        req0(1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0, 1'b1);
        req0(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1'b1);
        req0(1'b0, 32'h20, 32'h0,        4'b0000, 32'h11BB33DD, 1'b0, 1'b1);
        // Errors: misaligned, out of range, out-of-range store leaves word 0 alone
        req0(1'b0, 32'h22,  32'h0,        4'b0000, 32'h0, 1'b1, 1'b1);
        req0(1'b0, 32'h400, 32'h0,        4'b0000, 32'h0, 1'b1, 1'b1);
        req0(1'b1, 32'h400, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1, 1'b1);
        req0(1'b0, 32'h0,   32'h0,        4'b0000, 32'h0, 1'b0, 1'b1);
        // No-op store and last word
        req0(1'b1, 32'h10,  32'h12345678, 4'b0000, 32'h0, 1'b0, 1'b1);
        req0(1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b0, 1'b1);
        req0(1'b1, 32'h3FC, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, 1'b1);
        req0(1'b0, 32'h3FC, 32'h0,        4'b0000, 32'hCAFEF00D, 1'b0, 1'b1);
        drain();

        // Back-pressure: response held while a new request waits
        @(posedge clk);
        #1 rr0 = 1'b0;
        req0(1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0, 1'b1);
        n = 0;
        while (!rv0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_rsp_valid_seen", {31'b0, rv0}, 32'd1);
        snap_rd  = rd0;
        snap_err = er0;
        fork
            req0(1'b0, 32'h3FC, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0, 1'b1);
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("hold_rsp_valid", {31'b0, rv0}, 32'd1);
                    chk("hold_rdata", rd0, snap_rd);
                    chk("hold_err", {31'b0, er0}, {31'b0, snap_err});
                    chk("hold_req_ready", {31'b0, rdy0}, 32'd0);
                end
                chk("hold_no_accept", 32'(q0.size()), 32'd1);
                @(posedge clk);
                #1 rr0 = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("hold_release_idle", {31'b0, rdy0}, 32'd1);
            end
        join
        drain();

        // Asynchronous reset while a store waits
        req0(1'b1, 32'h30, 32'h55555555, 4'b1111, 32'h0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("abort_req_ready", {31'b0, rdy0}, 32'd1);
        chk("abort_rsp_valid", {31'b0, rv0}, 32'd0);
        chk("abort_rdata", rd0, 32'd0);
        chk("abort_err", {31'b0, er0}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        req0(1'b0, 32'h30, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1);
        req0(1'b0, 32'h10, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1);
        drain();

        // LATENCY=1 instance, back-to-back
        req1(1'b1, 32'h8, 32'h12345678, 4'b1111, 32'h0, 1'b0);
        req1(1'b0, 32'h8, 32'h0, 4'b0000, 32'h12345678, 1'b1);
        req1(1'b0, 32'h8, 32'h0, 4'b0000, 32'h12345678, 1'b1);
        req1(1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
